// File: rtl/equation_sequencer.sv
// Arithmetic quiz sequencer: draws random equations from an LFSR, shows them on
// frame boundaries, times the player's answer and keeps score across a game.
`timescale 1ns/1ps
module equation_sequencer #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          TIME_FRAMES = 600,
  parameter int          HOLD_FRAMES = 60,
  parameter int          NUM_ROUNDS  = 10,
  parameter int          MAX_TRIES   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       ans_valid,
  input  logic [6:0] ans_value,
  output logic [6:0] num1,
  output logic [6:0] num2,
  output logic [2:0] operator,
  output logic       eq_visible,
  output logic       result_ok,
  output logic       result_bad,
  output logic [6:0] score,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, GEN, SHOW, ASK, RESULT, DONE} state_t;

  localparam logic [15:0] TIME_LIM  = 16'(TIME_FRAMES - 1);
  localparam logic [15:0] HOLD_LIM  = 16'(HOLD_FRAMES - 1);
  localparam logic [7:0]  TRY_LIM   = 8'(MAX_TRIES - 1);
  localparam logic [7:0]  ROUND_LIM = 8'(NUM_ROUNDS - 1);

  state_t      state, state_next;
  logic [15:0] lfsr, lfsr_next;
  logic [15:0] frame_cnt;
  logic [7:0]  try_cnt;
  logic [7:0]  round_cnt;
  logic [6:0]  pend_n1, pend_n2, pend_exp, exp_cur;
  logic [1:0]  pend_op;

  logic gen_take, gen_fall, commit, ok_set, bad_set;
  logic frame_inc, frame_clr, try_inc, try_clr, round_inc, game_clr;

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v >= 7'd99) ? 7'd99 : v + 7'd1;
  endfunction

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  logic [1:0]  c_op;
  logic [6:0]  c_a, c_b;
  logic [3:0]  c_db;
  logic [4:0]  c_q;
  logic [7:0]  c_sum;
  logic [13:0] c_prod;
  logic [8:0]  c_dprod;
  logic        cand_ok;
  logic [6:0]  cand_n1, cand_n2, cand_exp;

  assign c_op    = lfsr[1:0];
  assign c_a     = lfsr[8:2];
  assign c_b     = lfsr[15:9];
  assign c_db    = lfsr[12:9];
  assign c_q     = lfsr[6:2];
  assign c_sum   = {1'b0, c_a} + {1'b0, c_b};
  assign c_prod  = {7'd0, c_a} * {7'd0, c_b};
  assign c_dprod = {5'd0, c_db} * {4'd0, c_q};

  always_comb begin
    cand_ok  = 1'b0;
    cand_n1  = c_a;
    cand_n2  = c_b;
    cand_exp = '0;
    case (c_op)
      2'd0: begin
        cand_ok  = (c_a <= 7'd99) && (c_b <= 7'd99) && (c_sum <= 8'd99);
        cand_exp = c_sum[6:0];
      end
      2'd1: begin
        cand_ok  = (c_a <= 7'd99) && (c_b <= 7'd99) && (c_a >= c_b);
        cand_exp = c_a - c_b;
      end
      2'd2: begin
        // Operands also bounded so a zero factor cannot expose a 100..127 operand
        cand_ok  = (c_a <= 7'd99) && (c_b <= 7'd99) && (c_prod <= 14'd99);
        cand_exp = c_prod[6:0];
      end
      default: begin
        cand_ok  = (c_db != 4'd0) && (c_db <= 4'd9) && (c_dprod <= 9'd99);
        cand_n1  = c_dprod[6:0];
        cand_n2  = {3'd0, c_db};
        cand_exp = {2'd0, c_q};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    gen_take   = 1'b0;
    gen_fall   = 1'b0;
    commit     = 1'b0;
    ok_set     = 1'b0;
    bad_set    = 1'b0;
    frame_inc  = 1'b0;
    frame_clr  = 1'b0;
    try_inc    = 1'b0;
    try_clr    = 1'b0;
    round_inc  = 1'b0;
    game_clr   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          game_clr   = 1'b1;
          try_clr    = 1'b1;
          state_next = GEN;
        end
      end
      GEN: begin
        if (cand_ok) begin
          gen_take   = 1'b1;
          try_clr    = 1'b1;
          state_next = SHOW;
        end else if (try_cnt == TRY_LIM) begin
          gen_fall   = 1'b1;
          try_clr    = 1'b1;
          state_next = SHOW;
        end else begin
          try_inc = 1'b1;
        end
      end
      SHOW: begin
        if (frame_tick) begin
          commit     = 1'b1;
          frame_clr  = 1'b1;
          state_next = ASK;
        end
      end
      ASK: begin
        // An answer takes priority over a coincident timeout tick
        if (ans_valid) begin
          ok_set     = (ans_value == exp_cur);
          bad_set    = (ans_value != exp_cur);
          frame_clr  = 1'b1;
          state_next = RESULT;
        end else if (frame_tick) begin
          if (frame_cnt == TIME_LIM) begin
            bad_set    = 1'b1;
            frame_clr  = 1'b1;
            state_next = RESULT;
          end else begin
            frame_inc = 1'b1;
          end
        end
      end
      RESULT: begin
        if (frame_tick) begin
          if (frame_cnt == HOLD_LIM) begin
            frame_clr  = 1'b1;
            round_inc  = 1'b1;
            state_next = (round_cnt == ROUND_LIM) ? DONE : GEN;
          end else begin
            frame_inc = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= SEED;
      frame_cnt  <= '0;
      try_cnt    <= '0;
      round_cnt  <= '0;
      pend_n1    <= '0;
      pend_n2    <= '0;
      pend_op    <= '0;
      pend_exp   <= '0;
      exp_cur    <= '0;
      num1       <= '0;
      num2       <= '0;
      operator   <= '0;
      score      <= '0;
      result_ok  <= 1'b0;
      result_bad <= 1'b0;
    end else begin
      lfsr       <= lfsr_next;
      result_ok  <= ok_set;
      result_bad <= bad_set;
      if (frame_clr)      frame_cnt <= '0;
      else if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
      if (try_clr)        try_cnt <= '0;
      else if (try_inc)   try_cnt <= try_cnt + 8'd1;
      if (game_clr)       round_cnt <= '0;
      else if (round_inc) round_cnt <= round_cnt + 8'd1;
      if (game_clr)       score <= '0;
      else if (ok_set)    score <= sat_inc(score);
      if (gen_take) begin
        pend_n1  <= cand_n1;
        pend_n2  <= cand_n2;
        pend_op  <= c_op;
        pend_exp <= cand_exp;
      end else if (gen_fall) begin
        pend_n1  <= 7'd1;
        pend_n2  <= 7'd1;
        pend_op  <= 2'd0;
        pend_exp <= 7'd2;
      end
      // Display operands only move on a frame boundary
      if (commit) begin
        num1     <= pend_n1;
        num2     <= pend_n2;
        operator <= {1'b0, pend_op};
        exp_cur  <= pend_exp;
      end
    end
  end

  assign eq_visible = (state == ASK) || (state == RESULT);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_equation_sequencer.sv
// Bench for equation_sequencer: table of round scenarios, scoreboard of expected
// result pulses, and a long random run checking equation invariants.
`timescale 1ns/1ps
module tb_equation_sequencer;

  localparam int TF = 3;
  localparam int HF = 1;
  localparam int NR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       ans_valid = 1'b0;
  logic [6:0] ans_value = 7'd0;
  logic [6:0] num1, num2, score;
  logic [2:0] operator;
  logic       eq_visible, result_ok, result_bad, done;

  always #5 clk = ~clk;

  equation_sequencer #(
    .SEED(16'hACE1), .TIME_FRAMES(TF), .HOLD_FRAMES(HF), .NUM_ROUNDS(NR), .MAX_TRIES(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_tick(frame_tick),
    .ans_valid(ans_valid), .ans_value(ans_value),
    .num1(num1), .num2(num2), .operator(operator), .eq_visible(eq_visible),
    .result_ok(result_ok), .result_bad(result_bad), .score(score), .done(done)
  );

  typedef struct {
    int   mode;    // 0 answer, 1 timeout, 2 answer on timeout tick, 3 double answer, 4 start in ASK, 5 answer outside ASK first
    logic exp_ok;  // correct value driven -> result_ok expected
    int   inc;
  } vec_t;

  int   n_checks = 0;
  int   n_pass = 0;
  logic exp_q[$];
  int   exp_score = 0;
  int   rounds_in_game = 0;

  task automatic chk(input string name, input logic ok, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic chk_eq(input string name, input int act, input int req);
    chk(name, act == req, act, req);
  endtask

  // Result scoreboard and frame-boundary monitor
  logic [6:0] p_n1 = 7'd0, p_n2 = 7'd0;
  logic [2:0] p_op = 3'd0;
  logic       p_tick = 1'b0, p_rst = 1'b0;
  always @(negedge clk) begin
    if (result_ok || result_bad) begin
      chk("ok_bad_exclusive", !(result_ok && result_bad), {result_ok, result_bad}, 1);
      chk("result_expected", exp_q.size() != 0, exp_q.size(), 1);
      if (exp_q.size() != 0) chk_eq("result_kind_ok", result_ok, exp_q.pop_front());
    end
    if (rst_n && p_rst && (num1 != p_n1 || num2 != p_n2 || operator != p_op))
      chk("change_after_tick", p_tick, p_tick, 1);
    p_n1   <= num1;
    p_n2   <= num2;
    p_op   <= operator;
    p_tick <= frame_tick;
    p_rst  <= rst_n;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic all_zero(input string name);
    chk_eq(name, {num1, num2, operator, eq_visible, result_ok, result_bad, score, done}, 0);
  endtask

  // mode 6: reset once the equation is up, instead of answering
  task automatic play(input int mode, input logic exp_ok, input int inc, input int gap,
                      output int nticks);
    int ans, k;
    logic [6:0] n1, n2, val;
    logic [2:0] op;
    nticks = 0;
    if (rounds_in_game == 0) begin
      do_start();
      exp_score = 0;
      chk_eq("start_clears_score", score, 0);
      chk_eq("start_clears_done", done, 0);
    end
    rounds_in_game++;
    if (mode == 5) begin
      ans_valid = 1'b1;
      ans_value = 7'd0;
      cyc();
      ans_valid = 1'b0;
    end
    for (int i = 0; i < 50 && !eq_visible; i++) begin
      repeat (i == 0 ? gap : 3) cyc();
      tick();
      nticks++;
    end
    chk("eq_visible_wait", eq_visible, eq_visible, 1);
    if (!eq_visible) return;
    n1 = num1;
    n2 = num2;
    op = operator;
    chk("operand_range", n1 <= 7'd99 && n2 <= 7'd99, (n1 > n2) ? n1 : n2, 99);
    ans = 0;
    case (op)
      3'd0: begin ans = n1 + n2; chk("add_bound", ans <= 99, ans, 99); end
      3'd1: begin ans = int'(n1) - int'(n2); chk("sub_nonneg", ans >= 0, ans, 0); end
      3'd2: begin ans = n1 * n2; chk("mul_bound", ans <= 99, ans, 99); end
      3'd3: begin
        chk("div_divisor", n2 >= 7'd1 && n2 <= 7'd9, n2, 9);
        if (n2 != 0) begin
          ans = n1 / n2;
          chk_eq("div_exact", n1 % n2, 0);
        end
      end
      default: chk("operator_code", 1'b0, op, 3);
    endcase
    chk("result_range", ans >= 0 && ans <= 99, ans, 99);
    if (mode == 6) begin
      #2 rst_n = 1'b0;
      #1 all_zero("reset_mid_ask");
      cyc();
      rst_n = 1'b1;
      rounds_in_game = 0;
      exp_score = 0;
      return;
    end
    val = exp_ok ? 7'(ans) : 7'((ans + 1) % 100);
    if (mode == 1 || mode == 2) begin
      repeat (2) begin
        repeat (3) cyc();
        tick();
      end
      repeat (3) cyc();
    end
    if (mode == 4) begin
      do_start();
      chk_eq("start_ignored_in_ask", eq_visible, 1);
    end
    exp_q.push_back(exp_ok);
    if (mode == 1) begin
      tick();
    end else begin
      ans_valid  = 1'b1;
      ans_value  = val;
      frame_tick = (mode == 2);
      cyc();
      frame_tick = 1'b0;
      if (mode == 3) cyc();
      ans_valid = 1'b0;
    end
    exp_score += inc;
    cyc();
    chk_eq("score", score, exp_score);
    chk_eq("scoreboard_drain", exp_q.size(), 0);
    k = 0;
    for (int i = 0; i < 50 && eq_visible; i++) begin
      repeat (3) cyc();
      tick();
      k++;
    end
    chk_eq("hold_ticks", k, HF);
    if (rounds_in_game == NR) begin
      chk_eq("done_after_last_round", done, 1);
      rounds_in_game = 0;
    end else begin
      chk_eq("done_mid_game", done, 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int nt;
    vecs[0] = '{0, 1'b1, 1};
    vecs[1] = '{0, 1'b0, 0};
    vecs[2] = '{1, 1'b0, 0};
    vecs[3] = '{2, 1'b1, 1};
    vecs[4] = '{2, 1'b0, 0};
    vecs[5] = '{3, 1'b1, 1};
    vecs[6] = '{4, 1'b1, 1};
    vecs[7] = '{5, 1'b1, 1};

    #2 all_zero("reset_state");
    cyc();
    cyc();
    rst_n = 1'b1;
    ans_valid = 1'b1;
    ans_value = 7'd0;
    cyc();
    ans_valid = 1'b0;
    repeat (3) begin
      repeat (3) cyc();
      tick();
      all_zero("idle_hold");
    end

    foreach (vecs[i]) play(vecs[i].mode, vecs[i].exp_ok, vecs[i].inc, 3, nt);

    // Reset in the middle of a game, then restart
    play(0, 1'b1, 1, 3, nt);
    play(6, 1'b1, 0, 3, nt);
    repeat (3) begin
      repeat (3) cyc();
      tick();
      all_zero("idle_after_reset");
    end
    play(0, 1'b1, 1, 40, nt);
    chk_eq("visible_after_one_tick", nt, 1);
    play(0, 1'b1, 1, 3, nt);

    for (int r = 0; r < 2000; r++) begin
      logic good;
      good = 1'($urandom_range(0, 1));
      play(0, good, good ? 1 : 0, 3, nt);
    end

    repeat (3) cyc();
    chk_eq("scoreboard_final", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/equation_sequencer.md
EQUATION_SEQUENCER -- requirements
Module: equation_sequencer

Interface
REQ-001 Parameter SEED, default 16'hACE1, the LFSR reset value; it SHALL be nonzero.
REQ-002 Parameter TIME_FRAMES, default 600, the answer window in frames (10 s at 60 Hz).
REQ-003 Parameter HOLD_FRAMES, default 60, the result display time in frames.
REQ-004 Parameter NUM_ROUNDS, default 10, the number of equations per game.
REQ-005 Parameter MAX_TRIES, default 32, the candidate rejections allowed before the fallback equation is used.
REQ-006 clk  in  1  system clock, the single clock domain.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse that begins a game.
REQ-009 frame_tick  in  1  one-cycle pulse at the first line of vertical blanking.
REQ-010 ans_valid  in  1  one-cycle pulse qualifying ans_value.
REQ-011 ans_value  in  7  player answer, 0..99.
REQ-012 num1  out  7  left operand for the equation display, 0..99.
REQ-013 num2  out  7  right operand, 0..99.
REQ-014 operator  out  3  0 '+', 1 '-', 2 'x', 3 '/'; codes 4..7 are never driven.
REQ-015 eq_visible  out  1  equation display enable.
REQ-016 result_ok  out  1  one-cycle pulse: correct answer.
REQ-017 result_bad  out  1  one-cycle pulse: wrong answer or timeout.
REQ-018 score  out  7  count of correct answers, 0..99.
REQ-019 done  out  1  high after the final round until the next start.

Function
REQ-020 A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every clk while rst_n is high, in every state.
REQ-021 The state machine SHALL have the states IDLE, GEN, SHOW, ASK, RESULT and DONE.
REQ-022 IDLE/DONE + start -> GEN. The same cycle SHALL clear score and the round counter, and SHALL clear done.
REQ-023 GEN SHALL evaluate one candidate per cycle as follows, and SHALL discard the candidate if any rule fails:
- op = lfsr[1:0], a = lfsr[8:2], b = lfsr[15:9].
- '+': a<=99, b<=99, a+b<=99.
- '-': a<=99, b<=99, a>=b.
- 'x': a*b<=99.
- '/': b = lfsr[12:9] must be 1..9; q = lfsr[6:2] must satisfy b*q<=99; then num1 = b*q, num2 = b, expected = q.
REQ-024 On an accepted candidate GEN SHALL latch the pending operands and the expected result (7 bits, 0..99) and go to SHOW.
REQ-025 After MAX_TRIES consecutive rejections GEN SHALL latch the fallback equation 1+1, expected 2, and go to SHOW.
REQ-026 num1, num2 and operator SHALL change only in the cycle after a frame_tick, never mid-frame.
REQ-027 In SHOW, the first frame_tick SHALL commit the pending values to the outputs, set eq_visible, clear the frame counter and enter ASK.
REQ-028 In ASK, each frame_tick SHALL increment the frame counter.
REQ-029 In ASK, ans_valid with ans_value==expected SHALL pulse result_ok and increment score, saturating at 99.
REQ-030 In ASK, ans_valid with any other ans_value SHALL pulse result_bad, with score unchanged.
REQ-031 In ASK, a frame_tick that brings the counter to TIME_FRAMES with no answer SHALL pulse result_bad.
REQ-032 Each of REQ-029..031 SHALL enter RESULT and clear the frame counter.
REQ-033 If ans_valid and the timeout frame_tick occur in the same cycle, the answer SHALL win.
REQ-034 ans_valid outside ASK SHALL be ignored; only the first ans_valid per round SHALL count.
REQ-035 RESULT SHALL keep eq_visible high for HOLD_FRAMES frame_ticks, then increment the round counter.
REQ-036 On leaving RESULT, the FSM SHALL go to DONE when the round counter reaches NUM_ROUNDS, else to GEN.
REQ-037 eq_visible SHALL be high only in ASK and RESULT.
REQ-038 done SHALL be high only in DONE.
REQ-039 start outside IDLE/DONE SHALL be ignored.
REQ-040 result_ok and result_bad SHALL never be high in the same cycle.

Reset
REQ-041 rst_n low SHALL asynchronously force the following, at any point including mid-round:
- state IDLE, lfsr = SEED;
- num1, num2, operator, score and all counters = 0;
- eq_visible, result_ok, result_bad and done = 0.
REQ-042 After rst_n deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-043 Reset mid-ASK -> all outputs 0, state IDLE; a later start -> new equation visible after the next frame_tick.
REQ-044 start, then frame_tick; the bench computes the answer from num1/operator/num2 and drives ans_valid -> result_ok for 1 cycle, score 0->1.
REQ-045 TIME_FRAMES=3, no answer -> result_bad on the 3rd frame_tick after commit; score unchanged.
REQ-046 ans_valid coincident with the timeout frame_tick, correct value -> result_ok only.
REQ-047 Operand invariants over 2000 rounds:
- outputs change only on the cycle after frame_tick;
- every result is 0..99;
- '/' exact, num2 in 1..9;
- '-' non-negative.
REQ-048 NUM_ROUNDS=2, HOLD_FRAMES=1 -> done asserts after the 2nd RESULT; start clears score and done.
